param_eprom_ctrl: RTL and testbench
===================================

Name: param_eprom_ctrl

Overview:
Parametrised, command-driven non-volatile memory model with flash-style semantics: a word program can only clear bits, and sector or chip erase sets words to all-ones. Program and erase are multi-cycle operations sequenced by an internal FSM and counter, with a valid/ready command handshake and busy/done/err status. A registered read port is independent of the command port and stays usable while an operation is in progress. The block replaces the single-cycle write/erase EPROM as the parametrised next-generation storage block.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 4, address width; depth = 2**ADDR_W words
SECTOR_W, 2, log2 of words per sector; must be ≤ ADDR_W
PROG_CYCLES, 4, busy cycles per program; must be ≥ 1
ERASE_CYCLES, 8, busy cycles per sector or chip erase; must be ≥ 1

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command can be accepted
cmd_op  in  2  00 illegal, 01 PROGRAM, 10 SECTOR_ERASE, 11 CHIP_ERASE
cmd_addr  in  ADDR_W  target word; for SECTOR_ERASE, the upper ADDR_W-SECTOR_W bits select the sector
cmd_wdata  in  DATA_W  program data
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  registered read data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  status, valid only while done=1

Behaviour:
- Power-up array contents: word i = (i+1) truncated to DATA_W. Reset never modifies the array.
- Reset values: rd_data=0, busy=0, done=0, err=0, FSM=IDLE, counter=0. cmd_ready=0 while rst=1.
- cmd_ready = (state==IDLE) && !rst. A command is accepted at the edge where cmd_valid && cmd_ready.
- FSM states: IDLE, PROG, ERASE.
  - IDLE to PROG on an accepted op 01. The counter loads PROG_CYCLES-1.
  - IDLE to ERASE on an accepted op 10 or 11. The counter loads ERASE_CYCLES-1.
  - Op, address and data are latched when the command is accepted.
- In PROG or ERASE, busy=1 and the counter decrements each cycle. At the edge where the counter is 0:
  - the array commits;
  - the FSM returns to IDLE;
  - done is set to 1 for one cycle.
- Cycle timing: accept at the edge ending cycle T; busy is 1 in cycles T+1 through T+N; done=1 and cmd_ready=1 in cycle T+N+1. A new command can be accepted in that same cycle.
- PROGRAM commit: mem[a] <= mem[a] & wdata. err=1 if (wdata & ~mem[a]) != 0, i.e. an attempt to set a bit; the AND result is still written.
- SECTOR_ERASE commit: every word in the selected sector becomes all-ones in a single cycle; err=0.
- CHIP_ERASE commit: every word becomes all-ones; err=0.
- Illegal op 00: accepted, no busy. done=1 and err=1 in the next cycle; the array is unchanged.
- Read: rd_data <= mem[rd_addr] every cycle, including while busy.
  - The read sees the pre-commit value when it coincides with the commit edge (read-before-write).
  - During an operation, the target address reads its old value until the commit.
- rst during PROG or ERASE aborts the operation: no commit, no done, and busy=0 in the next cycle.
- Changes to cmd_* after acceptance have no effect on the operation in progress.

Decomposition:
- Shared package: cmd_op encodings (OP_ILLEGAL, OP_PROG, OP_SERASE, OP_CERASE), FSM state enum, and ERASED_WORD = all-ones constant.
- Sub-module eprom_store: the array with power-up initialisation, one registered read port, and one write-enable port providing word write plus sector-fill and chip-fill strobes.
- The FSM, counter, handshake and err computation live in param_eprom_ctrl.

Test Plan:
1. Release reset; set rd_addr=5 -> rd_data=0x0006 one cycle later; cmd_ready=1, busy=0.
2. SECTOR_ERASE with cmd_addr=4 accepted at cycle T -> busy=1 in cycles T+1..T+8; done=1, err=0 at T+9; addresses 4..7 read 0xFFFF; address 3 reads 0x0004; address 8 reads 0x0009.
3. After scenario 2:
   - PROGRAM addr 4, data 0x12F0 -> 4 busy cycles, then done=1 with err=0; addr 4 reads 0x12F0.
   - PROGRAM addr 4, data 0x00FF -> done=1 with err=1; addr 4 reads 0x00F0.
4. Hold a second PROGRAM on cmd_valid while busy -> cmd_ready=0 throughout busy; the command is accepted in the done cycle; rd_addr=target reads the old value until that command commits.
5. CHIP_ERASE, then assert rst in the 3rd busy cycle -> busy=0 in the next cycle, no done pulse; addr 0 reads 0x0001 and addr 15 reads 0x0010.
6. Op 00 with addr 2 -> no busy; done=1 and err=1 in the next cycle; addr 2 still reads 0x0003.

Source files
------------

// File: rtl/param_eprom_ctrl_pkg.sv
// Shared definitions for the parametrised flash-style EPROM controller.
//   - cmd_op encodings accepted on the command port
//   - controller FSM state encoding
//   - ERASED_WORD: the all-ones erase pattern (sliced to DATA_W by users;
//     DATA_W must not exceed ERASED_W)
//   - cnt_width(): width of a down-counter that must hold values 0..n-1
package param_eprom_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_PROG    = 2'b01,
        OP_SERASE  = 2'b10,
        OP_CERASE  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PROG  = 2'b01,
        ST_ERASE = 2'b10
    } state_e;

    localparam int              ERASED_W    = 64;
    localparam logic [ERASED_W-1:0] ERASED_WORD = '1;

    // A counter loaded with n-1 needs clog2(n) bits, but never fewer than 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_eprom_ctrl_store.sv
// eprom_store: storage array for param_eprom_ctrl.
// The array powers up with word i = i+1 (truncated to DATA_W) and has no
// reset of its own; only the read register is reset.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (read register only)
//   rd_addr_i           read address, sampled every cycle
//   rd_data_o           registered read data (old value on a write edge)
//   we_i                word write of wdata_i at waddr_i
//   sector_fill_i       fill the sector containing waddr_i with all-ones
//   chip_fill_i         fill every word with all-ones
//   waddr_i, wdata_i    write address / data
//   wcur_o              current contents at waddr_i (for read-modify-write)
module eprom_store
    import param_eprom_ctrl_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int SECTOR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic              sector_fill_i,
    input  logic              chip_fill_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] wcur_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    function automatic logic [DEPTH-1:0][DATA_W-1:0] init_image();
        logic [DEPTH-1:0][DATA_W-1:0] img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = DATA_W'(i + 1);
        end
        return img;
    endfunction

    // Power-up contents come from the declaration initialiser, so reset
    // never touches the array.
    logic [DEPTH-1:0][DATA_W-1:0] mem_q = init_image();
    logic [DATA_W-1:0]            rd_data_q;

    assign wcur_o    = mem_q[waddr_i];
    assign rd_data_o = rd_data_q;

    // Sector match compares the address bits above the sector offset; the
    // shift form stays legal when SECTOR_W == ADDR_W (single sector).
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (chip_fill_i ||
                (sector_fill_i && ((ADDR_W'(i) >> SECTOR_W) == (waddr_i >> SECTOR_W)))) begin
                mem_q[i] <= ERASED_WORD[DATA_W-1:0];
            end else if (we_i && (waddr_i == ADDR_W'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/param_eprom_ctrl.sv
// param_eprom_ctrl: command-driven flash-style memory model.
// PROGRAM can only clear bits (mem &= wdata, err if a set was attempted);
// SECTOR_ERASE / CHIP_ERASE set words to all-ones. Program and erase take
// PROG_CYCLES / ERASE_CYCLES busy cycles, then commit with a one-cycle done.
// The read port is independent and keeps working while busy.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE, not in reset)
//   cmd_op                00 illegal, 01 program, 10 sector erase, 11 chip erase
//   cmd_addr, cmd_wdata   target word / program data (latched on accept)
//   rd_addr, rd_data      registered read port
//   busy                  operation in progress
//   done, err             one-cycle completion pulse; err valid with done
// Constraints: SECTOR_W <= ADDR_W, PROG_CYCLES >= 1, ERASE_CYCLES >= 1.
module param_eprom_ctrl
    import param_eprom_ctrl_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int SECTOR_W     = 2,
    parameter int PROG_CYCLES  = 4,
    parameter int ERASE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_CYC = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CNT_W   = cnt_width(MAX_CYC);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    cmd_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              last_cycle;
    logic              commit_en;
    logic [DATA_W-1:0] store_cur;
    logic [DATA_W-1:0] prog_word;
    logic              prog_err;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;

    // The commit edge is the one where the counter sits at zero. Gating with
    // rst makes a reset in that same cycle abort instead of commit.
    assign last_cycle = (state_q != ST_IDLE) && (cnt_q == '0);
    assign commit_en  = last_cycle && !rst;

    // Flash semantics: bits can only be cleared; any 1 in wdata over a 0 in
    // the array is an attempted set.
    assign prog_word = store_cur & wdata_q;
    assign prog_err  = |(wdata_q & ~store_cur);

    eprom_store #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SECTOR_W (SECTOR_W)
    ) u_store (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .we_i          (commit_en && (state_q == ST_PROG)),
        .sector_fill_i (commit_en && (state_q == ST_ERASE) && (op_q == OP_SERASE)),
        .chip_fill_i   (commit_en && (state_q == ST_ERASE) && (op_q == OP_CERASE)),
        .waddr_i       (addr_q),
        .wdata_i       (prog_word),
        .wcur_o        (store_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ILLEGAL;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready is simply "in IDLE" here since rst is low.
                    if (cmd_valid) begin
                        op_q    <= cmd_op_e'(cmd_op);
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        case (cmd_op_e'(cmd_op))
                            OP_PROG: begin
                                state_q <= ST_PROG;
                                cnt_q   <= CNT_W'(PROG_CYCLES - 1);
                                busy_q  <= 1'b1;
                            end
                            OP_SERASE, OP_CERASE: begin
                                state_q <= ST_ERASE;
                                cnt_q   <= CNT_W'(ERASE_CYCLES - 1);
                                busy_q  <= 1'b1;
                            end
                            default: begin
                                // Illegal op: accepted, never busy, fails at once.
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PROG, ST_ERASE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= (state_q == ST_PROG) ? prog_err : 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_param_eprom_ctrl.sv
// Scoreboard bench for param_eprom_ctrl (default parameters).
// Stimulus drives just after the rising edge and pushes expectations into
// queues; the monitor compares on the falling edge.
module tb_param_eprom_ctrl;
    import param_eprom_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;

    param_eprom_ctrl #(
        .DATA_W(16), .ADDR_W(4), .SECTOR_W(2), .PROG_CYCLES(4), .ERASE_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic err; int len; } done_exp_t;
    typedef struct { logic rdy; logic bsy; } st_exp_t;

    done_exp_t   doneq[$];
    logic [15:0] rdq[$];
    st_exp_t     stq[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   stim_to = 0;
    logic rd_pend = 1'b0, st_pend = 1'b0;
    logic rd_chk_q = 1'b0, st_chk_q = 1'b0;
    logic end_req = 1'b0, ended = 1'b0;
    int   busy_run = 0;

    // A request made in cycle k is checked on the falling edge of cycle k+1.
    always @(posedge clk) begin
        rd_chk_q <= rd_pend;
        st_chk_q <= st_pend;
    end

    always @(negedge clk) begin : monitor
        logic [15:0] re;
        st_exp_t     se;
        done_exp_t   de;
        if (rd_chk_q && rdq.size() > 0) begin
            re = rdq.pop_front();
            n_cmp++;
            if (rd_data !== re) begin
                n_bad++;
                $display("FAIL rd_data @%0t: got %h want %h", $time, rd_data, re);
            end
        end
        if (st_chk_q && stq.size() > 0) begin
            se = stq.pop_front();
            n_cmp++;
            if (cmd_ready !== se.rdy || busy !== se.bsy) begin
                n_bad++;
                $display("FAIL status @%0t: got ready=%b busy=%b want ready=%b busy=%b",
                         $time, cmd_ready, busy, se.rdy, se.bsy);
            end
        end
        if (done === 1'b1) begin
            if (doneq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done @%0t: unexpected done pulse, want none", $time);
            end else begin
                de = doneq.pop_front();
                n_cmp += 2;
                if (err !== de.err) begin
                    n_bad++;
                    $display("FAIL done_err @%0t: got %b want %b", $time, err, de.err);
                end
                if (busy_run != de.len) begin
                    n_bad++;
                    $display("FAIL busy_len @%0t: got %0d want %0d", $time, busy_run, de.len);
                end
            end
            busy_run = 0;
        end
        if (rst === 1'b1)        busy_run = 0;
        else if (busy === 1'b1)  busy_run++;
        else if (done !== 1'b1)  busy_run = 0;
        if (end_req && !ended) begin
            n_cmp++;
            if (doneq.size() != 0 || rdq.size() != 0 || stq.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: got done=%0d rd=%0d st=%0d pending want 0",
                         doneq.size(), rdq.size(), stq.size());
            end
            n_cmp++;
            if (stim_to != 0) begin
                n_bad++;
                $display("FAIL ready_timeout: got %0d timeouts want 0", stim_to);
            end
            ended = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_pend = 1'b0;
        st_pend = 1'b0;
    endtask

    task automatic rd_req(input logic [3:0] a, input logic [15:0] e);
        rd_addr = a;
        rd_pend = 1'b1;
        rdq.push_back(e);
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e);
        rd_req(a, e);
        tick();
    endtask

    task automatic st_req(input logic r, input logic b);
        st_exp_t s;
        s.rdy = r;
        s.bsy = b;
        st_pend = 1'b1;
        stq.push_back(s);
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 64 && !cmd_ready; i++) tick();
        if (!cmd_ready) stim_to++;
    endtask

    // Issue one command; returns in the first cycle after acceptance with
    // the cmd_* lines scrambled to show they are latched.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [15:0] d,
                         input logic exp_done, input logic e_err, input int e_len);
        done_exp_t x;
        wait_rdy();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        if (exp_done) begin
            x.err = e_err;
            x.len = e_len;
            doneq.push_back(x);
        end
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b01;
        cmd_addr  = ~a;
        cmd_wdata = 16'hA5A5;
    endtask

    initial begin : stim
        done_exp_t x;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
        cmd_wdata = '0; rd_addr = '0;
        tick(); tick();

        // Reset state
        st_req(1'b0, 1'b0); rd_req(4'd5, 16'h0000);
        tick(); tick();
        rst = 1'b0;

        // Power-up contents
        rd_req(4'd5, 16'h0006); st_req(1'b1, 1'b0);
        tick();

        // Sector erase of sector 1 (words 4..7)
        issue(OP_SERASE, 4'd4, 16'h0000, 1'b1, 1'b0, 8);
        rd_req(4'd4, 16'h0005); st_req(1'b0, 1'b1);
        tick();
        wait_rdy();
        rd(4'd4, 16'hFFFF); rd(4'd5, 16'hFFFF); rd(4'd6, 16'hFFFF); rd(4'd7, 16'hFFFF);
        rd(4'd3, 16'h0004); rd(4'd8, 16'h0009);

        // Programs: clean clear, then attempted set
        issue(OP_PROG, 4'd4, 16'h12F0, 1'b1, 1'b0, 4);
        wait_rdy();
        rd(4'd4, 16'h12F0);
        issue(OP_PROG, 4'd4, 16'h00FF, 1'b1, 1'b1, 4);
        wait_rdy();
        rd(4'd4, 16'h00F0);

        // Second program held on cmd_valid while the first is busy
        issue(OP_PROG, 4'd8, 16'h0001, 1'b1, 1'b0, 4);
        cmd_valid = 1'b1; cmd_op = OP_PROG; cmd_addr = 4'd8; cmd_wdata = 16'h0000;
        x.err = 1'b0; x.len = 4;
        doneq.push_back(x);
        repeat (3) begin
            st_req(1'b0, 1'b1); rd_req(4'd8, 16'h0009);
            tick();
        end
        rd_req(4'd8, 16'h0009); st_req(1'b1, 1'b0);  // commit edge: old value
        tick();
        rd_req(4'd8, 16'h0001);                        // done cycle: accepted here
        if (!cmd_ready) stim_to++;
        tick();
        cmd_valid = 1'b0; cmd_addr = 4'd3; cmd_wdata = 16'hFFFF;
        rd_req(4'd8, 16'h0001); st_req(1'b0, 1'b1);
        tick();
        wait_rdy();
        rd(4'd8, 16'h0000);

        // Chip erase aborted by reset in its 3rd busy cycle
        issue(OP_CERASE, 4'd0, 16'h0000, 1'b0, 1'b0, 0);
        tick(); tick();
        rst = 1'b1;
        st_req(1'b1, 1'b0);
        tick();
        rst = 1'b0;
        rd(4'd0, 16'h0001); rd(4'd15, 16'h0010);
        repeat (10) tick();

        // Illegal op
        issue(OP_ILLEGAL, 4'd2, 16'h0000, 1'b1, 1'b1, 0);
        rd_req(4'd2, 16'h0003); st_req(1'b1, 1'b0);
        tick();

        // Full chip erase
        issue(OP_CERASE, 4'd0, 16'h0000, 1'b1, 1'b0, 8);
        wait_rdy();
        rd(4'd0, 16'hFFFF); rd(4'd15, 16'hFFFF); rd(4'd9, 16'hFFFF);

        tick();
        end_req = 1'b1;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no finish by %0t want finish", $time);
        $fatal(1);
    end

endmodule
